rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
// PURPOSE
//  Shares one AHB-lite master port between the rv32 core's instruction-fetch and data-access ports.
//  Data has fixed priority; a streak limit prevents fetch starvation.
//  Runs one non-pipelined transfer at a time: address phase, data phase with wait states, registered response.
//  Sits between rv32_top and the bus/memory side (I/D memories, AHB-to-APB bridge).
// PARAMETERS
//  ADDR_W        32   address width (data fixed at 32 bits, 4 byte strobes)
//  MAX_D_STREAK  4    consecutive data grants allowed while i_req_in pending (>=1)
//  TIMEOUT       255  max hready_in-low cycles in a phase before forced error; 0 = disabled
// PORTS
//  clk_in        in   1       clock, rising edge
//  rst_in        in   1       reset, asynchronous, active-high
//  i_req_in      in   1       fetch request; hold with i_addr_in until i_ready_out
//  i_addr_in     in   ADDR_W  fetch address
//  i_rdata_out   out  32      fetch read data, valid with i_ready_out
//  i_ready_out   out  1       1-cycle pulse: fetch transfer complete
//  i_err_out     out  1       1-cycle pulse with i_ready_out: bus error or timeout
//  d_req_in      in   1       data request; hold with payload until d_ready_out
//  d_we_in       in   1       1 = write, 0 = read
//  d_addr_in     in   ADDR_W  data address
//  d_wdata_in    in   32      write data
//  d_mask_in     in   4       write byte strobes
//  d_rdata_out   out  32      data read data, valid with d_ready_out
//  d_ready_out   out  1       1-cycle pulse: data transfer complete
//  d_err_out     out  1       1-cycle pulse with d_ready_out: bus error or timeout
//  haddr_out     out  ADDR_W  bus address
//  htrans_out    out  2       2'b00 IDLE, 2'b10 NONSEQ
//  hwrite_out    out  1       bus write
//  hwstrb_out    out  4       bus byte strobes (0 on reads)
//  hwdata_out    out  32      bus write data, driven in data phase
//  hrdata_in     in   32      bus read data
//  hready_in     in   1       bus ready / phase extension
//  hresp_in      in   1       bus error response
//  grant_out     out  2       current owner: 01 fetch, 10 data, 00 none
// BEHAVIOUR
//  - Reset: all outputs 0 (htrans_out=2'b00, grant_out=2'b00), FSM=IDLE, streak=0, timeout counter=0.
//    Asserting reset mid-transfer aborts it; no ready/err pulse is issued.
//  - FSM IDLE->ADDR->DATA->RESP->IDLE.
//  - IDLE: arbitrate on registered edge; none pending -> stay. Winner's payload registered onto bus outputs.
//  - Arbitration: d_req_in wins unless i_req_in=1 and streak==MAX_D_STREAK.
//    Data grant: streak+1 (saturates at MAX_D_STREAK). Fetch grant: streak=0. Fetch alone: granted.
//  - ADDR: htrans_out=NONSEQ; stay while hready_in=0, else -> DATA.
//  - DATA: htrans_out=IDLE, hwdata_out valid for writes; stay while hready_in=0.
//    On hready_in=1: capture hrdata_in (0 if hresp_in=1 or write), -> RESP.
//  - RESP: pulse ready_out of owner (err_out if hresp_in was 1); grant_out=00; -> IDLE.
//  - Latency (zero wait): req sampled at edge 0, ready pulse in cycle after edge 3; one transfer per 4 cycles.
//  - Timeout: counter counts hready_in=0 cycles in ADDR/DATA. Reaching TIMEOUT -> RESP with err=1, rdata=0.
//    Counter clears on every phase change.
//  - The non-owner's ready/err never pulse. Requests arriving during a transfer wait for IDLE.
//    Simultaneous requests are resolved by the arbitration rule above.
//  - Requester keeping req high after its ready pulse = new request, re-arbitrated in IDLE.
// TESTING
//  1. Reset, d read 0x100, hrdata=0xDEADBEEF, hready=1 -> htrans NONSEQ 1 cycle, d_ready+rdata 0xDEADBEEF 3 cycles after req.
//  2. i_req and d_req both held high for 20 transfers, MAX_D_STREAK=4 -> grant sequence D,D,D,D,I repeating.
//  3. d write 0x200, data 0x12345678, mask 4'b0011, 2 wait cycles in DATA -> hwstrb 0011 held; d_ready 2 cycles later.
//  4. Fetch, hresp_in=1 with hready_in=1 in DATA -> i_ready and i_err pulse together, i_rdata=0.
//  5. TIMEOUT=8, hready_in stuck 0 -> err pulse after 8 stall cycles; FSM back to IDLE; next request serviced.
//  6. rst_in asserted in DATA of a read -> all outputs 0 asynchronously; no ready pulse; clean transfer after release.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// Shares one AHB-lite master port between the rv32 fetch and data ports.
// Data has fixed priority, bounded by a streak limit so fetch is never starved.
module rv32_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              i_req_in,
  input  logic [ADDR_W-1:0] i_addr_in,
  output logic [31:0]       i_rdata_out,
  output logic              i_ready_out,
  output logic              i_err_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [31:0]       d_wdata_in,
  input  logic [3:0]        d_mask_in,
  output logic [31:0]       d_rdata_out,
  output logic              d_ready_out,
  output logic              d_err_out,
  output logic [ADDR_W-1:0] haddr_out,
  output logic [1:0]        htrans_out,
  output logic              hwrite_out,
  output logic [3:0]        hwstrb_out,
  output logic [31:0]       hwdata_out,
  input  logic [31:0]       hrdata_in,
  input  logic              hready_in,
  input  logic              hresp_in,
  output logic [1:0]        grant_out
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_ownerData;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [3:0]        r_hwstrb;
  logic [31:0]       r_wdata;
  logic [SW-1:0]     r_streak;
  logic [TW-1:0]     r_toCnt;
  logic [31:0]       r_rdata;
  logic              r_errFlag;
  logic              r_iReady;
  logic              r_dReady;
  logic              r_iErr;
  logic              r_dErr;

  logic w_anyReq;
  logic w_grantData;
  logic w_streakFull;
  logic w_timeoutHit;

  // Data wins unless fetch is waiting and data already used up its streak.
  assign w_anyReq     = i_req_in | d_req_in;
  assign w_streakFull = (r_streak == SW'(MAX_D_STREAK));
  assign w_grantData  = d_req_in && !(i_req_in && w_streakFull);
  assign w_timeoutHit = (TIMEOUT != 0) && !hready_in && (r_toCnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          w_nextState = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_timeoutHit) begin
          w_nextState = ST_RESP;
        end else if (hready_in) begin
          w_nextState = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_timeoutHit || hready_in) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    htrans_out = 2'b00;
    grant_out  = 2'b00;
    hwdata_out = 32'h0;
    if (r_state == ST_ADDR) begin
      htrans_out = 2'b10;
    end
    if (r_state == ST_ADDR || r_state == ST_DATA) begin
      grant_out = r_ownerData ? 2'b10 : 2'b01;
    end
    if (r_state == ST_DATA && r_hwrite) begin
      hwdata_out = r_wdata;
    end
  end

  // Transfer datapath: latch winner payload, track stalls, register the response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ownerData <= 1'b0;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hwstrb    <= 4'b0000;
      r_wdata     <= 32'h0;
      r_streak    <= '0;
      r_toCnt     <= '0;
      r_rdata     <= 32'h0;
      r_errFlag   <= 1'b0;
      r_iReady    <= 1'b0;
      r_dReady    <= 1'b0;
      r_iErr      <= 1'b0;
      r_dErr      <= 1'b0;
    end else begin
      r_iReady <= 1'b0;
      r_dReady <= 1'b0;
      r_iErr   <= 1'b0;
      r_dErr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_ownerData <= w_grantData;
            r_toCnt     <= '0;
            r_errFlag   <= 1'b0;
            if (w_grantData) begin
              r_haddr  <= d_addr_in;
              r_hwrite <= d_we_in;
              r_hwstrb <= d_we_in ? d_mask_in : 4'b0000;
              r_wdata  <= d_wdata_in;
              r_streak <= w_streakFull ? r_streak : r_streak + 1'b1;
            end else begin
              r_haddr  <= i_addr_in;
              r_hwrite <= 1'b0;
              r_hwstrb <= 4'b0000;
              r_wdata  <= 32'h0;
              r_streak <= '0;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (w_timeoutHit) begin
            r_toCnt   <= '0;
            r_errFlag <= 1'b1;
            r_rdata   <= 32'h0;
          end else if (hready_in) begin
            r_toCnt <= '0;
            if (r_state == ST_DATA) begin
              r_rdata   <= (hresp_in || r_hwrite) ? 32'h0 : hrdata_in;
              r_errFlag <= hresp_in;
            end
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_iReady <= !r_ownerData;
          r_dReady <= r_ownerData;
          r_iErr   <= !r_ownerData && r_errFlag;
          r_dErr   <= r_ownerData && r_errFlag;
        end
        default: begin
          r_toCnt <= '0;
        end
      endcase
    end
  end

  assign i_ready_out = r_iReady;
  assign d_ready_out = r_dReady;
  assign i_err_out   = r_iErr;
  assign d_err_out   = r_dErr;
  assign i_rdata_out = r_iReady ? r_rdata : 32'h0;
  assign d_rdata_out = r_dReady ? r_rdata : 32'h0;
  assign haddr_out   = r_haddr;
  assign hwrite_out  = r_hwrite;
  assign hwstrb_out  = r_hwstrb;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: latency, arbitration streak, wait states,
// bus error, timeout and asynchronous reset abort.
module tb_rv32_mem_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        i_req_in;
  logic [31:0] i_addr_in;
  logic [31:0] i_rdata_out;
  logic        i_ready_out;
  logic        i_err_out;
  logic        d_req_in;
  logic        d_we_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic [3:0]  d_mask_in;
  logic [31:0] d_rdata_out;
  logic        d_ready_out;
  logic        d_err_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [3:0]  hwstrb_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in;
  logic        hready_in;
  logic        hresp_in;
  logic [1:0]  grant_out;

  int total;
  int bad;

  rv32_mem_arbiter #(
    .ADDR_W      (32),
    .MAX_D_STREAK(4),
    .TIMEOUT     (8)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_req_in   (i_req_in),
    .i_addr_in  (i_addr_in),
    .i_rdata_out(i_rdata_out),
    .i_ready_out(i_ready_out),
    .i_err_out  (i_err_out),
    .d_req_in   (d_req_in),
    .d_we_in    (d_we_in),
    .d_addr_in  (d_addr_in),
    .d_wdata_in (d_wdata_in),
    .d_mask_in  (d_mask_in),
    .d_rdata_out(d_rdata_out),
    .d_ready_out(d_ready_out),
    .d_err_out  (d_err_out),
    .haddr_out  (haddr_out),
    .htrans_out (htrans_out),
    .hwrite_out (hwrite_out),
    .hwstrb_out (hwstrb_out),
    .hwdata_out (hwdata_out),
    .hrdata_in  (hrdata_in),
    .hready_in  (hready_in),
    .hresp_in   (hresp_in),
    .grant_out  (grant_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dReq,
                               input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [3:0] dMask);
    i_req_in   = iReq;
    i_addr_in  = iAddr;
    d_req_in   = dReq;
    d_we_in    = dWe;
    d_addr_in  = dAddr;
    d_wdata_in = dWdata;
    d_mask_in  = dMask;
  endtask

  task automatic resetDut();
    rst_in    = 1'b1;
    hready_in = 1'b1;
    hresp_in  = 1'b0;
    hrdata_in = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();
    waitCycle();
    rst_in = 1'b0;
    waitCycle();
  endtask

  initial begin
    int n;
    logic expI;
    total = 0;
    bad   = 0;

    // Reset state
    resetDut();
    checkOutput("rst_htrans", htrans_out, 2'b00);
    checkOutput("rst_grant", grant_out, 2'b00);
    checkOutput("rst_haddr", haddr_out, 32'h0);
    checkOutput("rst_ready", {i_ready_out, d_ready_out, i_err_out, d_err_out}, 4'h0);

    // Zero-wait data read
    hrdata_in = 32'hDEADBEEF;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    waitCycle();
    checkOutput("t1_htrans_addr", htrans_out, 2'b10);
    checkOutput("t1_grant", grant_out, 2'b10);
    checkOutput("t1_haddr", haddr_out, 32'h100);
    checkOutput("t1_hwstrb", hwstrb_out, 4'h0);
    waitCycle();
    checkOutput("t1_htrans_data", htrans_out, 2'b00);
    waitCycle();
    checkOutput("t1_early_ready", d_ready_out, 1'b0);
    waitCycle();
    checkOutput("t1_d_ready", d_ready_out, 1'b1);
    checkOutput("t1_d_rdata", d_rdata_out, 32'hDEADBEEF);
    checkOutput("t1_d_err", d_err_out, 1'b0);
    checkOutput("t1_i_ready", i_ready_out, 1'b0);
    d_req_in = 1'b0;

    // Both requesters held: D,D,D,D,I repeating
    resetDut();
    hrdata_in = 32'h0BADF00D;
    applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      expI = (k % 5 == 4);
      n = 0;
      while (grant_out == 2'b00 && n < 20) begin
        waitCycle();
        n++;
      end
      checkOutput($sformatf("t2_grant_%0d", k), grant_out, expI ? 2'b01 : 2'b10);
      checkOutput($sformatf("t2_haddr_%0d", k), haddr_out, expI ? 32'h1000 : 32'h2000);
      n = 0;
      while (!(i_ready_out || d_ready_out) && n < 20) begin
        waitCycle();
        n++;
      end
      checkOutput($sformatf("t2_iready_%0d", k), i_ready_out, expI);
      checkOutput($sformatf("t2_dready_%0d", k), d_ready_out, !expI);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();

    // Write with two DATA wait states
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011);
    waitCycle();
    checkOutput("t3_htrans", htrans_out, 2'b10);
    checkOutput("t3_hwrite", hwrite_out, 1'b1);
    checkOutput("t3_hwstrb_addr", hwstrb_out, 4'b0011);
    waitCycle();
    checkOutput("t3_hwdata", hwdata_out, 32'h12345678);
    hready_in = 1'b0;
    waitCycle();
    checkOutput("t3_hwstrb_wait1", hwstrb_out, 4'b0011);
    waitCycle();
    checkOutput("t3_hwdata_wait2", hwdata_out, 32'h12345678);
    checkOutput("t3_no_ready", d_ready_out, 1'b0);
    hready_in = 1'b1;
    waitCycle();
    checkOutput("t3_resp_no_ready", d_ready_out, 1'b0);
    waitCycle();
    checkOutput("t3_d_ready", d_ready_out, 1'b1);
    checkOutput("t3_d_rdata", d_rdata_out, 32'h0);
    checkOutput("t3_d_err", d_err_out, 1'b0);
    d_req_in = 1'b0;

    // Fetch with bus error in DATA
    resetDut();
    hrdata_in = 32'hCAFEF00D;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();
    checkOutput("t4_grant", grant_out, 2'b01);
    waitCycle();
    hresp_in = 1'b1;
    waitCycle();
    hresp_in = 1'b0;
    waitCycle();
    checkOutput("t4_i_ready", i_ready_out, 1'b1);
    checkOutput("t4_i_err", i_err_out, 1'b1);
    checkOutput("t4_i_rdata", i_rdata_out, 32'h0);
    checkOutput("t4_d_ready", {d_ready_out, d_err_out}, 2'b00);
    i_req_in = 1'b0;

    // Timeout with hready stuck low, then a normal fetch
    resetDut();
    hrdata_in = 32'h55AA55AA;
    hready_in = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    n = 0;
    do begin
      waitCycle();
      n++;
    end while (!d_ready_out && n < 30);
    checkOutput("t5_cycles", n, 10);
    checkOutput("t5_d_err", d_err_out, 1'b1);
    checkOutput("t5_d_rdata", d_rdata_out, 32'h0);
    d_req_in  = 1'b0;
    hready_in = 1'b1;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitCycle();
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("t5_next_ready", i_ready_out, 1'b1);
    checkOutput("t5_next_err", i_err_out, 1'b0);
    checkOutput("t5_next_rdata", i_rdata_out, 32'h55AA55AA);
    i_req_in = 1'b0;

    // Asynchronous reset in DATA phase
    resetDut();
    hrdata_in = 32'hA5A5F00F;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    waitCycle();
    waitCycle();
    rst_in = 1'b1;
    #1;
    checkOutput("t6_async_htrans", htrans_out, 2'b00);
    checkOutput("t6_async_grant", grant_out, 2'b00);
    checkOutput("t6_async_haddr", haddr_out, 32'h0);
    n = 0;
    for (int c = 0; c < 3; c++) begin
      waitCycle();
      if (d_ready_out || i_ready_out) n++;
    end
    checkOutput("t6_no_pulse", n, 0);
    rst_in = 1'b0;
    waitCycle();
    checkOutput("t6_restart_htrans", htrans_out, 2'b10);
    waitCycle();
    waitCycle();
    waitCycle();
    checkOutput("t6_restart_ready", d_ready_out, 1'b1);
    checkOutput("t6_restart_rdata", d_rdata_out, 32'hA5A5F00F);
    d_req_in = 1'b0;
    waitCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
